fetch_ctrl: RTL and testbench



---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_buf.sv | 80 ++++++++
 rtl/fetch_ctrl.sv | 84 ++++++++
 tb/tb_fetch_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          BUF_DEPTH_FIXED  = 2;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry skid FIFO between instruction memory return and decode.
// The head entry lives in its own register so instr/instr_pc come straight from flops.
module fetch_buf
   import fetch_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         push_i,
   input  fetch_entry_t push_data_i,
   input  logic         pop_i,
   output fetch_entry_t head_o,
   output logic [1:0]   count_o,
   output logic         valid_o
);

   fetch_entry_t head_q, head_d;
   fetch_entry_t tail_q, tail_d;
   logic [1:0]   count_q, count_d;
   logic         pop_eff;

   assign pop_eff = pop_i & (count_q != 2'd0);

   // Next-state: flush wins; a pop frees the head before a same-cycle push lands.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         case ({push_i, pop_eff})
            2'b10: begin
               if (count_q == 2'd0) begin
                  head_d  = push_data_i;
                  count_d = 2'd1;
               end else if (count_q == 2'd1) begin
                  tail_d  = push_data_i;
                  count_d = 2'd2;
               end
            end
            2'b01: begin
               if (count_q == 2'd2) begin
                  head_d  = tail_q;
                  count_d = 2'd1;
               end else begin
                  count_d = 2'd0;
               end
            end
            2'b11: begin
               if (count_q == 2'd2) begin
                  head_d = tail_q;
                  tail_d = push_data_i;
               end else begin
                  head_d = push_data_i;
               end
            end
            default: ;
         endcase
      end
   end

   // Storage and occupancy registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head_o  = head_q;
   assign count_o = count_q;
   assign valid_o = (count_q != 2'd0);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, tracks the single in-flight read of a
// one-cycle-latency memory and feeds returned words to decode through fetch_buf.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          BUF_DEPTH = BUF_DEPTH_FIXED
)(
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
);

   // PCs are kept as word indices; byte offset bits are always zero.
   logic [29:0]  pc_q, pc_d;
   logic [29:0]  inflight_pc_q, inflight_pc_d;
   logic         inflight_q, inflight_d;
   logic         pop;
   logic         issue;
   logic [2:0]   occ_after_pop;
   logic [1:0]   buf_count;
   fetch_entry_t head;
   fetch_entry_t push_data;
   logic         unused_redirect_bits;

   assign unused_redirect_bits = ^redirect_pc[1:0];

   assign pop = instr_valid & instr_ready & ~redirect_valid;

   // Only issue when the word would still have a slot once it returns.
   assign occ_after_pop = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue = ~rst & ~redirect_valid & (int'(occ_after_pop) < BUF_DEPTH);

   // PC and in-flight tracking next-state.
   always_comb begin
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = redirect_pc[31:2];
      end else if (issue) begin
         pc_d = pc_q + 30'd1;
      end
   end

   // PC and in-flight registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC[31:2];
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   assign mem_addr  = {2'b00, pc_q};
   assign push_data = '{pc: {inflight_pc_q, 2'b00}, instr: mem_rdata};

   fetch_buf u_buf (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (redirect_valid),
      .push_i      (inflight_q),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (buf_count),
      .valid_o     (instr_valid)
   );

   assign instr    = head.instr;
   assign instr_pc = head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
   import fetch_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   int tests;
   int fails;

   logic [31:0] mem [0:255];

   fetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) mem_rdata <= mem[mem_addr[7:0]];

   function automatic logic [31:0] exp_word(input logic [31:0] pc);
      logic [31:0] idx;
      idx = pc >> 2;
      case (idx)
         32'd0:   return 32'h1000_0517;
         32'd1:   return 32'h0005_0513;
         32'd2:   return 32'h0005_2583;
         32'd3:   return 32'h00C5_86B3;
         32'd4:   return 32'h00D5_2423;
         default: return INSTR_NOP | (idx << 20);
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst && dut.inflight_q && dut.u_buf.count_q == 2'd2 && !dut.pop) begin
         fails++;
         $display("FAIL fifo_overflow push into full FIFO at t=%0t", $time);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in cycle 0: reset just released, DUT in reset state.
   task automatic do_reset(input logic rdy);
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      instr_ready = rdy;
   endtask

   task automatic chk_head(input string name, input logic [31:0] pc);
      tests++;
      if (instr_valid !== 1'b1 || instr_pc !== pc || instr !== exp_word(pc)) begin
         fails++;
         $display("FAIL %s got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                  name, instr_valid, instr_pc, instr, pc, exp_word(pc));
      end
   endtask

   task automatic chk_invalid(input string name);
      tests++;
      if (instr_valid !== 1'b0) begin
         fails++;
         $display("FAIL %s instr_valid got %0b exp 0", name, instr_valid);
      end
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      chk_invalid("reset_valid");
      tests++;
      if (instr !== 32'h0 || instr_pc !== 32'h0) begin
         fails++;
         $display("FAIL reset_head got instr=%h pc=%h exp 0/0", instr, instr_pc);
      end
      tests++;
      if (mem_addr !== 32'h0) begin
         fails++;
         $display("FAIL reset_mem_addr got %h exp 0", mem_addr);
      end
   endtask

   task automatic test_stream();
      do_reset(1'b1);
      tests++;
      if (mem_addr !== 32'h0) begin
         fails++;
         $display("FAIL stream_c0_addr got %h exp 0", mem_addr);
      end
      step();
      chk_invalid("stream_c1_valid");
      tests++;
      if (mem_addr !== 32'h1) begin
         fails++;
         $display("FAIL stream_c1_addr got %h exp 1", mem_addr);
      end
      step();
      for (int k = 0; k < 5; k++) begin
         chk_head("stream_seq", 32'(k * 4));
         step();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc;
      int got;
      do_reset(1'b0);
      step();
      step();
      for (int k = 0; k < 10; k++) step();
      tests++;
      if (mem_addr !== 32'h2 || dut.u_buf.count_q !== 2'd2) begin
         fails++;
         $display("FAIL bp_hold got addr=%h count=%0d exp addr=2 count=2",
                  mem_addr, dut.u_buf.count_q);
      end
      chk_head("bp_head_held", 32'h0);
      instr_ready = 1'b1;
      exp_pc = 32'h0;
      got = 0;
      for (int k = 0; k < 20 && got < 5; k++) begin
         if (instr_valid) begin
            chk_head("bp_resume_seq", exp_pc);
            exp_pc += 4;
            got++;
         end
         step();
      end
      tests++;
      if (got != 5) begin
         fails++;
         $display("FAIL bp_resume_count got %0d exp 5", got);
      end
   endtask

   task automatic test_redirect();
      do_reset(1'b1);
      step();
      step();
      step();
      step();
      chk_head("redir_pre", 32'h8);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_000C;
      step();
      redirect_valid = 1'b0;
      chk_invalid("redir_r1");
      step();
      chk_invalid("redir_r2");
      step();
      chk_head("redir_r3", 32'hC);
      step();
      chk_head("redir_r4", 32'h10);
   endtask

   task automatic test_redirect_full();
      do_reset(1'b0);
      for (int k = 0; k < 5; k++) step();
      tests++;
      if (dut.u_buf.count_q !== 2'd2) begin
         fails++;
         $display("FAIL rfull_count got %0d exp 2", dut.u_buf.count_q);
      end
      instr_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0010;
      step();
      redirect_valid = 1'b0;
      chk_invalid("rfull_r1");
      step();
      chk_invalid("rfull_r2");
      step();
      chk_head("rfull_r3", 32'h10);
   endtask

   task automatic test_misaligned();
      do_reset(1'b1);
      step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0007;
      step();
      redirect_valid = 1'b0;
      step();
      step();
      chk_head("misalign", 32'h4);
   endtask

   task automatic test_back_to_back();
      do_reset(1'b1);
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0010;
      step();
      redirect_pc = 32'h0000_0008;
      step();
      redirect_valid = 1'b0;
      chk_invalid("b2b_r1");
      step();
      chk_invalid("b2b_r2");
      step();
      chk_head("b2b_r3", 32'h8);
      step();
      chk_head("b2b_r4", 32'hC);
   endtask

   task automatic test_reset_mid();
      do_reset(1'b1);
      step();
      step();
      step();
      chk_head("rmid_pre", 32'h4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_invalid("rmid_valid");
      tests++;
      if (instr !== 32'h0 || instr_pc !== 32'h0 || mem_addr !== 32'h0) begin
         fails++;
         $display("FAIL rmid_state got instr=%h pc=%h addr=%h exp 0/0/0",
                  instr, instr_pc, mem_addr);
      end
      step();
      chk_invalid("rmid_c1");
      step();
      chk_head("rmid_restart0", 32'h0);
      step();
      chk_head("rmid_restart1", 32'h4);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = exp_word(32'(i * 4));
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_full();
      test_misaligned();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
